alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 clk  input  1  Rising-edge clock for all state.
REQ-002 reset  input  1  Asynchronous, active-high reset.
REQ-003 instr  input  16  Instruction word: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc/imm-low.
REQ-004 instr_valid  input  1  Instruction offered.
REQ-005 instr_ready  output  1  Sequencer accepts; transfer = instr_valid & instr_ready.
REQ-006 alu_op, shamt  output  5 each  Registered ALU op code and signed shift amount.
REQ-007 imm_ext  output  16  Registered extended immediate.
REQ-008 use_imm  output  1  ALU b operand = imm_ext (1) or Rsrc (0).
REQ-009 rdest_addr, rsrc_addr  output  4 each  Register-file addresses.
REQ-010 flags_en, flags_sel  output  1, 5  PSR write enable and mask {C,F,Z,L,N}.
REQ-011 alu_flags  input  5  ALU masked flag outputs {C,F,Z,L,N}.
REQ-012 alu_y_valid  input  1  ALU result is architectural.
REQ-013 rf_we  output  1  Register-file write strobe.
REQ-014 psr, psr_c_in  output  5, 1  PSR register and psr[4].
REQ-015 resume  input  1  Leaves HALT.
REQ-016 halted, illegal  output  1 each  In HALT; sticky illegal-opcode flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC, HALT.
REQ-018 In IDLE, instr_ready SHALL be 1; on a transfer, the instruction SHALL be decoded into registered outputs and the state SHALL move to EXEC.
REQ-019 EXEC SHALL last exactly one cycle, with rf_we = alu_y_valid; at its closing edge, psr SHALL become (psr & ~flags_sel) | (alu_flags & flags_sel) if flags_en; the state SHALL return to IDLE.
REQ-020 Latency SHALL be: accept at edge N; controls valid N..N+1; PSR and register file updated at edge N+1; next accept possible at edge N+2.
REQ-021 In EXEC and HALT, instr_ready SHALL be 0.
REQ-022 Outside EXEC, the decode outputs SHALL read as NOP (alu_op=29, flags_en=0, rf_we=0).
REQ-023 RR forms (op=0000) SHALL decode by ext: 0101 ADD=0, 0110 ADDU=2, 0111 ADDC=4, 1001 SUB=8, 1011 CMP=10, 0001 AND=14, 0010 OR=16, 0011 XOR=18, 1101 MOV=27; use_imm=0.
REQ-024 Immediate forms SHALL decode by op: 0101 ADDI=1, 0110 ADDUI=3, 0111 ADDCI=5, 1001 SUBI=9, 1011 CMPI=11, 0001 ANDI=15, 0010 ORI=17, 0011 XORI=19, 1101 MOVI=27, 1111 LUI=28; imm8=instr[7:0]; use_imm=1.
REQ-025 Immediate extension SHALL be: ADDI, ADDCI, SUBI, CMPI sign-extend imm8; all other immediate forms zero-extend imm8.
REQ-026 op=1000 with ext[3:1]=000 SHALL decode as LSHI=22, shamt={instr[4],instr[3:0]}.
REQ-027 The flag mask SHALL be: ADD/ADDI/ADDC/ADDCI/SUB/SUBI flags_en=1, sel=11000; CMP/CMPI flags_en=1, sel=00111; all other ops flags_en=0, sel=00000.
REQ-028 instr=0x0000 (WAIT) SHALL go IDLE->HALT with no rf_we and no PSR change; halted=1 in HALT.
REQ-029 In HALT, a resume pulse SHALL return the state to IDLE at the next edge; resume in IDLE or EXEC SHALL be ignored.
REQ-030 Any unlisted encoding SHALL be illegal (see Configuration).

Reset
REQ-031 On reset: state=IDLE, psr=0, alu_op=29, shamt=0, imm_ext=0, use_imm=0, addresses=0, flags_en=0, flags_sel=0, rf_we=0, halted=0, illegal=0.
REQ-032 Reset asserted during EXEC SHALL abort the instruction: no PSR update, rf_we=0 immediately.

Configuration
REQ-033 Macro ALU_CTRL_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal encoding SHALL set illegal=1 and enter HALT; illegal clears only on reset.
- Undefined: an illegal encoding SHALL execute as NOP through EXEC, rf_we=0; illegal stays 0.

Verification
REQ-034 ADD R1,R2 (0x0152), alu_flags=10000 -> EXEC: alu_op=0, rdest=1, rsrc=2, sel=11000; after EXEC psr=10000, psr_c_in=1.
REQ-035 CMPI R3,#-1 (0xB3FF), psr=10000 preloaded, alu_flags=00101 -> alu_op=11, imm_ext=0xFFFF; psr=10101 (C preserved).
REQ-036 LUI R4,#0x12 (0xF412) -> alu_op=28, imm_ext=0x0012, flags_en=0, rf_we=1 with alu_y_valid=1; psr unchanged.
REQ-037 LSHI R5,#-3 (0x851D) -> alu_op=22, shamt=11101, flags_en=0.
REQ-038 WAIT (0x0000) with instr_valid held -> halted=1, instr_ready=0 for 10 cycles; resume pulse -> IDLE, next instr accepted.
REQ-039 Illegal 0x4000 -> with macro: illegal=1, halted=1; without: one NOP EXEC, back to IDLE; reset mid-EXEC of ADD -> psr stays 0.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: accepts one 16-bit instruction, decodes it into registered ALU
// controls for a single EXEC cycle, updates the PSR, and supports WAIT/HALT.
// Optional build macro ALU_CTRL_SEQ_ILLEGAL_TRAP_EN: illegal encodings trap into HALT.
module alu_ctrl_seq (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [15:0] instr_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   output logic [4:0]  alu_op_o,
   output logic [4:0]  shamt_o,
   output logic [15:0] imm_ext_o,
   output logic        use_imm_o,
   output logic [3:0]  rdest_addr_o,
   output logic [3:0]  rsrc_addr_o,
   output logic        flags_en_o,
   output logic [4:0]  flags_sel_o,
   input  logic [4:0]  alu_flags_i,
   input  logic        alu_y_valid_i,
   output logic        rf_we_o,
   output logic [4:0]  psr_o,
   output logic        psr_c_in_o,
   input  logic        resume_i,
   output logic        halted_o,
   output logic        illegal_o,
   output logic [1:0]  state_o
);

   // Handshake: an instruction transfers on a rising edge where instr_valid_i and
   // instr_ready_o are both 1; instr_ready_o depends only on the state, never on instr_valid_i.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HALT = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0]  alu_op;
      logic [4:0]  shamt;
      logic [15:0] imm;
      logic        use_imm;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic        fen;
      logic [4:0]  fsel;
      logic        wr;
   } ctrl_t;

   localparam logic [4:0] OP_NOP   = 5'd29;
   localparam ctrl_t      CTRL_NOP = '{OP_NOP, 5'd0, 16'd0, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0};

   state_t      state_q, state_d;
   ctrl_t       ctrl_q, dec;
   logic [4:0]  psr_q;
   logic        illegal_q;
   logic        dec_wait, dec_illegal, trap_illegal, accept;
   logic [3:0]  op, ext;
   logic [7:0]  imm8;
   logic [15:0] imm_sx, imm_zx;

   assign op     = instr_i[15:12];
   assign ext    = instr_i[7:4];
   assign imm8   = instr_i[7:0];
   assign imm_sx = {{8{imm8[7]}}, imm8};
   assign imm_zx = {8'd0, imm8};
   assign accept = (state_q == S_IDLE) && instr_valid_i;

   // Instruction decode
   always_comb begin
      dec         = CTRL_NOP;
      dec_wait    = 1'b0;
      dec_illegal = 1'b0;
      if (instr_i == 16'h0000) begin
         dec_wait = 1'b1;
      end else begin
         dec.rd = instr_i[11:8];
         dec.rs = instr_i[3:0];
         dec.wr = 1'b1;
         case (op)
            4'b0000: begin
               case (ext)
                  4'b0101: dec.alu_op = 5'd0;
                  4'b0110: dec.alu_op = 5'd2;
                  4'b0111: dec.alu_op = 5'd4;
                  4'b1001: dec.alu_op = 5'd8;
                  4'b1011: dec.alu_op = 5'd10;
                  4'b0001: dec.alu_op = 5'd14;
                  4'b0010: dec.alu_op = 5'd16;
                  4'b0011: dec.alu_op = 5'd18;
                  4'b1101: dec.alu_op = 5'd27;
                  default: dec_illegal = 1'b1;
               endcase
            end
            4'b0101: begin dec.alu_op = 5'd1;  dec.use_imm = 1'b1; dec.imm = imm_sx; end
            4'b0110: begin dec.alu_op = 5'd3;  dec.use_imm = 1'b1; dec.imm = imm_zx; end
            4'b0111: begin dec.alu_op = 5'd5;  dec.use_imm = 1'b1; dec.imm = imm_sx; end
            4'b1001: begin dec.alu_op = 5'd9;  dec.use_imm = 1'b1; dec.imm = imm_sx; end
            4'b1011: begin dec.alu_op = 5'd11; dec.use_imm = 1'b1; dec.imm = imm_sx; end
            4'b0001: begin dec.alu_op = 5'd15; dec.use_imm = 1'b1; dec.imm = imm_zx; end
            4'b0010: begin dec.alu_op = 5'd17; dec.use_imm = 1'b1; dec.imm = imm_zx; end
            4'b0011: begin dec.alu_op = 5'd19; dec.use_imm = 1'b1; dec.imm = imm_zx; end
            4'b1101: begin dec.alu_op = 5'd27; dec.use_imm = 1'b1; dec.imm = imm_zx; end
            4'b1111: begin dec.alu_op = 5'd28; dec.use_imm = 1'b1; dec.imm = imm_zx; end
            4'b1000: begin
               if (ext[3:1] == 3'b000) begin
                  dec.alu_op = 5'd22;
                  dec.shamt  = {instr_i[4], instr_i[3:0]};
               end else begin
                  dec_illegal = 1'b1;
               end
            end
            default: dec_illegal = 1'b1;
         endcase

         case (dec.alu_op)
            5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9: begin
               dec.fen  = 1'b1;
               dec.fsel = 5'b11000;
            end
            5'd10, 5'd11: begin
               dec.fen  = 1'b1;
               dec.fsel = 5'b00111;
            end
            default: begin
               dec.fen  = 1'b0;
               dec.fsel = 5'b00000;
            end
         endcase

         // Illegal encodings that are not trapped run through EXEC as a non-writing NOP.
         if (dec_illegal) begin
            dec = CTRL_NOP;
         end
      end
   end

`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
   assign trap_illegal = dec_illegal;
`else
   assign trap_illegal = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (dec_wait || trap_illegal) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC:  state_d = S_IDLE;
         S_HALT:  if (resume_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      instr_ready_o = 1'b0;
      halted_o      = 1'b0;
      rf_we_o       = 1'b0;
      case (state_q)
         S_IDLE:  instr_ready_o = 1'b1;
         S_EXEC:  rf_we_o       = ctrl_q.wr & alu_y_valid_i;
         S_HALT:  halted_o      = 1'b1;
         default: instr_ready_o = 1'b0;
      endcase
   end

   // Decoded controls are live only for the EXEC cycle and fall back to NOP afterwards.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ctrl_q <= CTRL_NOP;
      end else if (state_q == S_EXEC) begin
         ctrl_q <= CTRL_NOP;
      end else if (accept && (state_d == S_EXEC)) begin
         ctrl_q <= dec;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         psr_q <= 5'd0;
      end else if ((state_q == S_EXEC) && ctrl_q.fen) begin
         psr_q <= (psr_q & ~ctrl_q.fsel) | (alu_flags_i & ctrl_q.fsel);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         illegal_q <= 1'b0;
      end else if (accept && trap_illegal) begin
         illegal_q <= 1'b1;
      end
   end

   assign alu_op_o     = ctrl_q.alu_op;
   assign shamt_o      = ctrl_q.shamt;
   assign imm_ext_o    = ctrl_q.imm;
   assign use_imm_o    = ctrl_q.use_imm;
   assign rdest_addr_o = ctrl_q.rd;
   assign rsrc_addr_o  = ctrl_q.rs;
   assign flags_en_o   = ctrl_q.fen;
   assign flags_sel_o  = ctrl_q.fsel;
   assign psr_o        = psr_q;
   assign psr_c_in_o   = psr_q[4];
   assign illegal_o    = illegal_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed scoreboard bench for alu_ctrl_seq: drivers push expected EXEC controls and
// post-EXEC PSR; a monitor pops and compares whenever the sequencer is in EXEC.
module tb_alu_ctrl_seq;
   localparam int W = 42;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   logic        clk, reset;
   logic [15:0] instr;
   logic        instr_valid, instr_ready;
   logic [4:0]  alu_op, shamt;
   logic [15:0] imm_ext;
   logic        use_imm;
   logic [3:0]  rdest_addr, rsrc_addr;
   logic        flags_en;
   logic [4:0]  flags_sel, alu_flags;
   logic        alu_y_valid, rf_we;
   logic [4:0]  psr;
   logic        psr_c_in, resume, halted, illegal;
   logic [1:0]  state;
   logic [W-1:0] act_v;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   logic [4:0]   psr_exp_q[$];

   alu_ctrl_seq dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .instr_i       (instr),
      .instr_valid_i (instr_valid),
      .instr_ready_o (instr_ready),
      .alu_op_o      (alu_op),
      .shamt_o       (shamt),
      .imm_ext_o     (imm_ext),
      .use_imm_o     (use_imm),
      .rdest_addr_o  (rdest_addr),
      .rsrc_addr_o   (rsrc_addr),
      .flags_en_o    (flags_en),
      .flags_sel_o   (flags_sel),
      .alu_flags_i   (alu_flags),
      .alu_y_valid_i (alu_y_valid),
      .rf_we_o       (rf_we),
      .psr_o         (psr),
      .psr_c_in_o    (psr_c_in),
      .resume_i      (resume),
      .halted_o      (halted),
      .illegal_o     (illegal),
      .state_o       (state)
   );

   assign act_v = {alu_op, shamt, imm_ext, use_imm, rdest_addr, rsrc_addr,
                   flags_en, flags_sel, rf_we};

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] pk(input logic [4:0] op, input logic [4:0] sh,
                                       input logic [15:0] imm, input logic ui,
                                       input logic [3:0] rd, input logic [3:0] rs,
                                       input logic fen, input logic [4:0] fsel,
                                       input logic we);
      return {op, sh, imm, ui, rd, rs, fen, fsel, we};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver: offer one instruction in IDLE and queue its expected EXEC response
   task automatic issue(input logic [15:0] ins, input logic [4:0] fl, input logic yv,
                        input logic [W-1:0] e, input logic [W-1:0] m, input logic [4:0] p);
      int t;
      t = 0;
      @(negedge clk);
      while (!instr_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("ready_before_issue", instr_ready, 1);
      instr       = ins;
      instr_valid = 1'b1;
      alu_flags   = fl;
      alu_y_valid = yv;
      exp_q.push_back(e);
      msk_q.push_back(m);
      psr_exp_q.push_back(p);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Monitor / scoreboard
   initial begin
      logic [W-1:0] e, m;
      logic [4:0]   p;
      forever begin
         @(negedge clk);
         if (!reset && state == ST_EXEC) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_exec: got ctrl 0x%0h, expected no EXEC", act_v);
            end else begin
               e = exp_q.pop_front();
               m = msk_q.pop_front();
               p = psr_exp_q.pop_front();
               check("exec_ctrl", act_v & m, e & m);
               check("exec_ready_low", instr_ready, 0);
               @(posedge clk);
               #1;
               check("psr_after_exec", psr, p);
               check("psr_c_in", psr_c_in, p[4]);
               check("back_to_idle", state, ST_IDLE);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] full, nopm;
      int t;
      full = '1;
      nopm = pk(5'h1F, 5'd0, 16'd0, 1'b0, 4'd0, 4'd0, 1'b1, 5'h1F, 1'b1);
      reset = 1'b1; instr = 16'h0; instr_valid = 1'b0;
      alu_flags = 5'd0; alu_y_valid = 1'b0; resume = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_state", state, ST_IDLE);
      check("rst_psr", psr, 0);
      check("rst_ctrl", act_v, pk(5'd29, 0, 0, 0, 0, 0, 0, 0, 0));
      check("rst_ready", instr_ready, 1);
      check("rst_halted", halted, 0);
      check("rst_illegal", illegal, 0);

      // Arithmetic, compare, immediate and shift forms
      issue(16'h0152, 5'b10000, 1, pk(5'd0,  0, 16'h0000, 0, 4'h1, 4'h2, 1, 5'b11000, 1), full, 5'b10000);
      issue(16'hB3FF, 5'b00101, 1, pk(5'd11, 0, 16'hFFFF, 1, 4'h3, 4'hF, 1, 5'b00111, 1), full, 5'b10101);
      issue(16'hF412, 5'b11111, 1, pk(5'd28, 0, 16'h0012, 1, 4'h4, 4'h2, 0, 5'b00000, 1), full, 5'b10101);
      issue(16'h851D, 5'b11111, 1, pk(5'd22, 5'b11101, 16'h0000, 0, 4'h5, 4'hD, 0, 5'b00000, 1), full, 5'b10101);
      issue(16'h5280, 5'b01010, 0, pk(5'd1,  0, 16'hFF80, 1, 4'h2, 4'h0, 1, 5'b11000, 0), full, 5'b01101);
      issue(16'h2380, 5'b11111, 1, pk(5'd17, 0, 16'h0080, 1, 4'h3, 4'h0, 0, 5'b00000, 1), full, 5'b01101);
      issue(16'h0A93, 5'b00000, 1, pk(5'd8,  0, 16'h0000, 0, 4'hA, 4'h3, 1, 5'b11000, 1), full, 5'b00101);
      issue(16'h0071, 5'b10011, 1, pk(5'd4,  0, 16'h0000, 0, 4'h0, 4'h1, 1, 5'b11000, 1), full, 5'b10101);
      issue(16'h0234, 5'b01111, 1, pk(5'd18, 0, 16'h0000, 0, 4'h2, 4'h4, 0, 5'b00000, 1), full, 5'b10101);
      issue(16'h07D2, 5'b01111, 1, pk(5'd27, 0, 16'h0000, 0, 4'h7, 4'h2, 0, 5'b00000, 1), full, 5'b10101);
      issue(16'h7185, 5'b01000, 1, pk(5'd5,  0, 16'hFF85, 1, 4'h1, 4'h5, 1, 5'b11000, 1), full, 5'b01101);

      // WAIT with instr_valid held, then resume and accept the next instruction
      @(negedge clk);
      instr = 16'h0000; instr_valid = 1'b1; alu_flags = 5'b11111; alu_y_valid = 1'b1;
      @(posedge clk);
      #1;
      check("wait_state", state, ST_HALT);
      check("wait_rf_we", rf_we, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("halt_halted", halted, 1);
         check("halt_ready", instr_ready, 0);
      end
      check("halt_psr", psr, 5'b01101);
      instr = 16'h0163;
      exp_q.push_back(pk(5'd2, 0, 16'h0000, 0, 4'h1, 4'h3, 0, 5'b00000, 1));
      msk_q.push_back(full);
      psr_exp_q.push_back(5'b01101);
      resume = 1'b1;
      @(posedge clk);
      #1 resume = 1'b0;
      check("resume_idle", state, ST_IDLE);
      check("resume_halted", halted, 0);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      check("resume_accept", state, ST_EXEC);
      repeat (2) @(negedge clk);

      // Resume outside HALT has no effect
      resume = 1'b1;
      @(posedge clk);
      #1 resume = 1'b0;
      check("resume_in_idle", state, ST_IDLE);

      // Illegal encoding
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
      @(negedge clk);
      instr = 16'h4000; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      check("illegal_flag", illegal, 1);
      check("illegal_halted", halted, 1);
      check("illegal_psr", psr, 5'b01101);
      @(negedge clk);
      resume = 1'b1;
      @(posedge clk);
      #1 resume = 1'b0;
      check("illegal_resume", state, ST_IDLE);
      check("illegal_sticky", illegal, 1);
`else
      issue(16'h4000, 5'b11111, 1, pk(5'd29, 0, 0, 0, 0, 0, 0, 5'b00000, 0), nopm, 5'b01101);
      check("illegal_flag", illegal, 0);
      check("illegal_idle", state, ST_IDLE);
`endif

      // Reset in the middle of an ADD's EXEC cycle
      @(negedge clk);
      instr = 16'h0152; instr_valid = 1'b1; alu_flags = 5'b10000; alu_y_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      check("abort_in_exec", state, ST_EXEC);
      check("abort_rf_we_before", rf_we, 1);
      #1 reset = 1'b1;
      #1;
      check("abort_rf_we", rf_we, 0);
      check("abort_state", state, ST_IDLE);
      check("abort_psr", psr, 0);
      check("abort_illegal", illegal, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort_psr_after", psr, 0);
      check("abort_alu_op", alu_op, 5'd29);

      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
